// File: rtl/param_updown_counter_if.sv
// Control and status bundle for param_updown_counter: the master drives the
// count controls, the slave (the counter) returns the count and its flags.
interface param_updown_counter_if #(
  parameter int WIDTH = 32
);
  logic             enable;
  logic             inst;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] value;
  logic             at_max;
  logic             at_zero;
  logic             overflow;

  modport master (
    output enable, inst, load, load_value,
    input  value, at_max, at_zero, overflow
  );

  modport slave (
    input  enable, inst, load, load_value,
    output value, at_max, at_zero, overflow
  );
endinterface

// File: rtl/param_updown_counter.sv
// Up/down counter with parallel load; wraps by default, clamps at the limits when PARAM_UPDOWN_COUNTER_SATURATE_EN is defined.
// One cycle from enable/inst/load to value; at_max/at_zero follow value combinationally; always ready, no backpressure.
module param_updown_counter #(
  parameter int              WIDTH = 32,
  parameter longint unsigned STEP  = 1
) (
  input logic                   clock,
  input logic                   reset,
  param_updown_counter_if.slave bus
);

  localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);
`ifdef PARAM_UPDOWN_COUNTER_SATURATE_EN
  localparam logic [WIDTH-1:0] MAX_VAL = '1;
`endif

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_nxt;
  logic             overflow_q;
  logic             overflow_nxt;
  logic [WIDTH:0]   sum_up;
  logic [WIDTH:0]   sum_dn;
  logic             crossing;

  // One extra bit holds the carry (up) or borrow (down), flagging the boundary exactly.
  always_comb begin
    sum_up   = {1'b0, count} + STEP_X;
    sum_dn   = {1'b0, count} - STEP_X;
    crossing = bus.inst ? sum_dn[WIDTH] : sum_up[WIDTH];
  end

  always_comb begin
    count_nxt    = count;
    overflow_nxt = 1'b0;
    if (bus.load) begin
      count_nxt = bus.load_value;
    end else if (bus.enable) begin
      overflow_nxt = crossing;
`ifdef PARAM_UPDOWN_COUNTER_SATURATE_EN
      if (crossing) begin
        count_nxt = bus.inst ? '0 : MAX_VAL;
      end else begin
        count_nxt = bus.inst ? sum_dn[WIDTH-1:0] : sum_up[WIDTH-1:0];
      end
`else
      count_nxt = bus.inst ? sum_dn[WIDTH-1:0] : sum_up[WIDTH-1:0];
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      count      <= count_nxt;
      overflow_q <= overflow_nxt;
    end
  end

  assign bus.value    = count;
  assign bus.overflow = overflow_q;
  assign bus.at_max   = &count;
  assign bus.at_zero  = ~|count;

endmodule

// File: doc/param_updown_counter.md
PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, counter width in bits (legal range 2..64).
REQ-002 SHALL have parameter STEP, default 1, increment/decrement magnitude (legal range 1..2^(WIDTH-1)).
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  count enable; no count when low.
REQ-006 SHALL have port inst  input  1  direction instruction: 0 = count up, 1 = count down.
REQ-007 SHALL have port load  input  1  synchronous parallel-load strobe.
REQ-008 SHALL have port load_value  input  WIDTH  value captured when load is high.
REQ-009 SHALL have port value  output  WIDTH  current count, driven directly from the count register.
REQ-010 SHALL have port at_max  output  1  combinational, high iff value == 2^WIDTH-1.
REQ-011 SHALL have port at_zero  output  1  combinational, high iff value == 0.
REQ-012 SHALL have port overflow  output  1  registered one-cycle flag marking a boundary event on the previous edge.

Function
REQ-013 SHALL apply edge-time priority: reset > load > (enable and count) > hold.
REQ-014 SHALL, on an edge with load high and reset low, set value to load_value and overflow to 0, ignoring enable and inst.
REQ-015 SHALL, on an edge with enable high, load low and reset low, set value to value+STEP when inst=0 and value-STEP when inst=1.
REQ-016 SHALL, on an edge with enable, load and reset all low, hold value unchanged and set overflow to 0.
REQ-017 SHALL compute next value at WIDTH+1 bits so that boundary crossing is detected exactly for any legal STEP.
REQ-018 SHALL define a boundary event as: counting up with value+STEP > 2^WIDTH-1, or counting down with value < STEP.
REQ-019 SHALL, in wrap mode, produce value modulo 2^WIDTH on a boundary event (e.g. WIDTH=8, STEP=3: 254 up -> 1; 1 down -> 254).
REQ-020 SHALL set overflow to 1 on the edge following a counted cycle with a boundary event, else 0 on every counted edge.
REQ-021 SHALL give one-cycle latency from enable/inst/load sampling to value update; at_max/at_zero have zero latency from value.
REQ-022 SHALL allow inst to change on any cycle with no dead cycle or penalty.

Reset
REQ-023 SHALL, on an edge with reset high, set value to 0 and overflow to 0 regardless of all other inputs.
REQ-024 SHALL, after reset, present at_zero=1 and at_max=0.
REQ-025 SHALL allow reset asserted mid-count to abort the count on that edge; counting resumes on the first edge with reset low.

Configuration
REQ-026 SHALL use macro PARAM_UPDOWN_COUNTER_SATURATE_EN to select the boundary behaviour.
REQ-027 SHALL, with PARAM_UPDOWN_COUNTER_SATURATE_EN defined, clamp value to 2^WIDTH-1 (up) or 0 (down) on a boundary event and still set overflow for that event.
REQ-028 SHALL, with the macro defined, keep value at the limit while counting further past it and set overflow on every such edge.
REQ-029 SHALL, without the macro, use wrap mode per REQ-019; the saturation logic SHALL NOT be synthesised.

Verification
REQ-030 SHALL cover reset: WIDTH=8; reset=1 with load=1, load_value=0x55, enable=1 -> value=0, overflow=0, at_zero=1.
REQ-031 SHALL cover up-wrap: WIDTH=8, STEP=1, no macro; load 0xFE, then enable=1, inst=0 for 3 cycles -> values 0xFF, 0x00, 0x01; overflow=1 only in the cycle value=0x00.
REQ-032 SHALL cover down-saturate: WIDTH=8, STEP=3, macro defined; load 4, then enable=1, inst=1 for 3 cycles -> values 1, 0, 0; overflow=0, 1, 1.
REQ-033 SHALL cover priority: value=10, same edge load=1, load_value=200, enable=1, inst=0 -> value=200, overflow=0.
REQ-034 SHALL cover hold and direction change: WIDTH=32; enable=0 for 2 cycles then inst toggled 0,1,0 with enable=1 from value 5 -> 5, 5, 6, 5, 6.
REQ-035 SHALL cover reset mid-count: counting up from 100, reset=1 for one edge, then enable=1, inst=0 -> 101, 0, 1.
